sprite_pixel_server: RTL and testbench
======================================

Name: sprite_pixel_server

Overview:
- Sprite-memory side of the player animation address generators.
- Loads encoded sprite pixels into on-chip RAM through a streaming load handshake.
- Serves per-pixel reads addressed by spriteAddress / playerOn with a fixed 2-cycle latency.
- Returns the colour index and a transparency-qualified pixel-on flag to the colour mapper.

Parameters:
- SPRITE_WORDS, 12800, number of sprite words held: 2 directions x 4 frames x 40x40.
- ADDR_W, 14, internal RAM address width; must satisfy 2^ADDR_W >= SPRITE_WORDS.
- PIX_W, 4, encoded pixel (colour index) width.
- TRANSPARENT_IDX, 4'h0, colour index treated as transparent.

Ports:
- frame_Clk  in  1  clock, all logic on rising edge.
- Reset  in  1  synchronous, active-high.
- load_start  in  1  single-cycle pulse; begin or restart a sprite load.
- load_valid  in  1  load_data is valid this cycle.
- load_ready  out  1  block accepts a load word this cycle.
- load_data  in  PIX_W  encoded pixel to write.
- sprite_ready  out  1  RAM fully loaded; reads are served.
- playerOn  in  1  current pixel lies inside the sprite box.
- spriteAddress  in  21  sprite RAM word address for the current pixel.
- pixelOn  out  1  opaque sprite pixel present; aligned 2 cycles after its inputs.
- pixelIndex  out  PIX_W  colour index, aligned with pixelOn.

Behaviour:
- Load FSM states: EMPTY, LOAD, READY.
- Reset: FSM to EMPTY, load_ptr=0, load_ready=0, sprite_ready=0, pixelOn=0, pixelIndex=0. Pipeline valid bits cleared. RAM contents are not cleared.
- EMPTY:
  - load_ready=0.
  - load_start moves to LOAD with load_ptr=0.
- LOAD:
  - load_ready=1.
  - When load_valid && load_ready: mem[load_ptr] <= load_data and load_ptr increments.
  - On the write where load_ptr == SPRITE_WORDS-1, move to READY next cycle; load_ready drops in the same cycle sprite_ready rises.
  - load_start in LOAD resets load_ptr to 0 and stays in LOAD. load_start has priority over a same-cycle write, and that write is discarded.
- READY:
  - sprite_ready=1, load_ready=0.
  - load_start moves to LOAD with load_ptr=0 and sprite_ready=0 from the next cycle.
- Read pipeline:
  - Stage 1 registers req_v = playerOn && sprite_ready, plus the address truncated to ADDR_W.
  - Stage 2 performs a registered RAM read and registers req_v.
  - Outputs follow stage 2: pixelIndex = read data, pixelOn = req_v_d2 && (data != TRANSPARENT_IDX).
  - When req_v_d2=0, pixelIndex is forced to 0.
  - Latency is exactly 2 frame_Clk cycles with one request per cycle and no stalls.
- Load/read collision:
  - A read whose stage-1 sample had sprite_ready=0 yields pixelOn=0.
  - Reads already in flight when a reload starts still complete with old or new RAM data; no guarantee which.
- Reset mid-load abandons the load. A fresh load_start is required, and sprite_ready stays 0 until it completes.

Optional Feature:
- Macro SPRITE_BOUND_CHECK_EN.
- When defined:
  - Adds output addr_error (1 bit).
  - spriteAddress >= SPRITE_WORDS with playerOn=1 and sprite_ready=1 forces req_v=0 for that pixel, so pixelOn=0 and pixelIndex=0 two cycles later.
  - Sets addr_error (sticky); Reset or load_start clears it.
- When undefined:
  - No addr_error port.
  - Address is truncated to ADDR_W LSBs and the RAM word at that location is returned unchecked.

Test Plan:
- Reset, then load_start, then stream SPRITE_WORDS words with data = addr[3:0] and load_valid held high -> load_ready high for 12800 cycles; sprite_ready=1 on the cycle after the last write.
- After load, drive playerOn=1 with spriteAddress 1,2,3 on consecutive cycles -> pixelIndex 1,2,3 and pixelOn=1 on cycles t+2..t+4.
- Read spriteAddress=16, whose data is 0 = TRANSPARENT_IDX, with playerOn=1 -> pixelOn=0, pixelIndex=0 two cycles later.
- Toggle load_valid 1/0 during load, then pulse load_start at word 500 -> load_ptr restarts at 0; sprite_ready rises only after a further 12800 accepted words.
- playerOn=1 before any load completes (sprite_ready=0) -> pixelOn stays 0; Reset asserted mid-load -> load_ready=0, sprite_ready=0 the next cycle.
- With SPRITE_BOUND_CHECK_EN, spriteAddress=12800 and playerOn=1 -> pixelOn=0 at t+2, addr_error=1 and held; next load_start clears it to 0.

Source files
------------

// File: rtl/sprite_pixel_server.sv
// sprite_pixel_server
//   Sprite-memory side of the player animation address generators. Encoded
//   sprite pixels are streamed into on-chip RAM through a valid/ready load
//   handshake. Per-pixel reads are then served with a fixed 2-cycle latency.
//
// Ports
//   frame_Clk      in   clock, all logic on rising edge
//   Reset          in   synchronous, active-high
//   load_start     in   pulse: begin or restart a sprite load
//   load_valid     in   load_data valid this cycle
//   load_ready     out  block accepts a load word this cycle
//   load_data      in   encoded pixel to write (PIX_W)
//   sprite_ready   out  RAM fully loaded, reads are served
//   playerOn       in   current pixel lies inside the sprite box
//   spriteAddress  in   sprite RAM word address (21 bits)
//   addr_error     out  sticky out-of-range read flag (SPRITE_BOUND_CHECK_EN only)
//   pixelOn        out  opaque sprite pixel present, 2 cycles after its inputs
//   pixelIndex     out  colour index, aligned with pixelOn
//
// Build option
//   SPRITE_BOUND_CHECK_EN  reject reads at spriteAddress >= SPRITE_WORDS and
//                          flag them on addr_error. Without it the address is
//                          truncated to ADDR_W bits and read unchecked.
//
// Load FSM
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_EMPTY | no valid sprite in RAM, waiting for load_start
//   ST_LOAD  | accepting load words, load_ptr is the next write address
//   ST_READY | RAM fully loaded, reads are served

module sprite_pixel_server #(
    parameter int                SPRITE_WORDS    = 12800,
    parameter int                ADDR_W          = 14,
    parameter int                PIX_W           = 4,
    parameter logic [PIX_W-1:0]  TRANSPARENT_IDX = 4'h0
) (
    input  logic             frame_Clk,
    input  logic             Reset,
    input  logic             load_start,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [PIX_W-1:0] load_data,
    output logic             sprite_ready,
    input  logic             playerOn,
    input  logic [20:0]      spriteAddress,
`ifdef SPRITE_BOUND_CHECK_EN
    output logic             addr_error,
`endif
    output logic             pixelOn,
    output logic [PIX_W-1:0] pixelIndex
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(SPRITE_WORDS - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_load_ptr;
    logic [ADDR_W-1:0] w_load_ptr_nxt;
    logic              w_wr_en;

    logic [PIX_W-1:0]  r_mem [0:SPRITE_WORDS-1];
    logic [PIX_W-1:0]  r_rd_data;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_req_v1;
    logic              r_req_v2;
    logic              w_req;

    // ---------------------------------------------------------------- load FSM
    always_ff @(posedge frame_Clk) begin
        if (Reset) begin
            r_state    <= ST_EMPTY;
            r_load_ptr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_load_ptr <= w_load_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_load_ptr_nxt = r_load_ptr;
        w_wr_en        = 1'b0;
        load_ready     = 1'b0;
        sprite_ready   = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (load_start) begin
                    w_state_nxt    = ST_LOAD;
                    w_load_ptr_nxt = '0;
                end
            end
            ST_LOAD: begin
                load_ready = 1'b1;
                // A restart wins over a same-cycle word, which is dropped.
                if (load_start) begin
                    w_load_ptr_nxt = '0;
                end else if (load_valid) begin
                    w_wr_en = 1'b1;
                    if (r_load_ptr == LAST_PTR) begin
                        w_state_nxt    = ST_READY;
                        w_load_ptr_nxt = '0;
                    end else begin
                        w_load_ptr_nxt = r_load_ptr + 1'b1;
                    end
                end
            end
            ST_READY: begin
                sprite_ready = 1'b1;
                if (load_start) begin
                    w_state_nxt    = ST_LOAD;
                    w_load_ptr_nxt = '0;
                end
            end
            default: begin
                w_state_nxt    = ST_EMPTY;
                w_load_ptr_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------ sprite RAM
    // No reset on the array or its read register so it maps onto block RAM;
    // the read data is qualified by r_req_v2 downstream.
    always_ff @(posedge frame_Clk) begin
        if (w_wr_en) begin
            r_mem[r_load_ptr] <= load_data;
        end
        r_rd_data <= r_mem[r_rd_addr];
    end

    // --------------------------------------------------------- read pipeline
`ifdef SPRITE_BOUND_CHECK_EN
    logic w_in_bound;
    logic r_addr_error;

    assign w_in_bound = (spriteAddress < 21'(SPRITE_WORDS));
    assign w_req      = playerOn && sprite_ready && w_in_bound;

    always_ff @(posedge frame_Clk) begin
        if (Reset || load_start) begin
            r_addr_error <= 1'b0;
        end else if (playerOn && sprite_ready && !w_in_bound) begin
            r_addr_error <= 1'b1;
        end
    end

    assign addr_error = r_addr_error;
`else
    // Upper address bits are intentionally ignored in the unchecked build.
    logic w_addr_hi_unused;

    assign w_addr_hi_unused = ^spriteAddress[20:ADDR_W];
    assign w_req            = playerOn && sprite_ready;
`endif

    always_ff @(posedge frame_Clk) begin
        if (Reset) begin
            r_req_v1  <= 1'b0;
            r_req_v2  <= 1'b0;
            r_rd_addr <= '0;
        end else begin
            r_req_v1  <= w_req;
            r_rd_addr <= spriteAddress[ADDR_W-1:0];
            r_req_v2  <= r_req_v1;
        end
    end

    assign pixelOn    = r_req_v2 && (r_rd_data != TRANSPARENT_IDX);
    assign pixelIndex = r_req_v2 ? r_rd_data : '0;

endmodule

// File: tb/tb_sprite_pixel_server.sv
// Self-checking bench for sprite_pixel_server. Read requests push their
// expected {pixelOn, pixelIndex} onto a scoreboard queue stamped with the
// cycle they must appear on; a negedge monitor pops and compares them.
// Loaded data is addr[3:0] (first load) and (addr+3)[3:0] (reload).
// Build with SPRITE_BOUND_CHECK_EN defined to exercise addr_error as well.

module tb_sprite_pixel_server;

    logic        frame_Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        load_start = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [3:0]  load_data = 4'h0;
    logic        sprite_ready;
    logic        playerOn = 1'b0;
    logic [20:0] spriteAddress = '0;
    logic        pixelOn;
    logic [3:0]  pixelIndex;
`ifdef SPRITE_BOUND_CHECK_EN
    logic        addr_error;
`endif

    sprite_pixel_server dut (
        .frame_Clk     (frame_Clk),
        .Reset         (Reset),
        .load_start    (load_start),
        .load_valid    (load_valid),
        .load_ready    (load_ready),
        .load_data     (load_data),
        .sprite_ready  (sprite_ready),
        .playerOn      (playerOn),
        .spriteAddress (spriteAddress),
`ifdef SPRITE_BOUND_CHECK_EN
        .addr_error    (addr_error),
`endif
        .pixelOn       (pixelOn),
        .pixelIndex    (pixelIndex)
    );

    always #5 frame_Clk = ~frame_Clk;

    int cyc = 0;
    always @(posedge frame_Clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        int         due;
        logic       on;
        logic [3:0] idx;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic        on_in;
        logic [20:0] addr;
        logic        exp_on;
        logic [3:0]  exp_idx;
    } vec_t;
    vec_t tbl[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Scoreboard monitor: outputs for a request driven at cycle c appear at c+2.
    always @(negedge frame_Clk) begin
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            exp_t e;
            e = sbq.pop_front();
            chk("sb_on_time", 32'(e.due), 32'(cyc));
            chk("pixelOn", 32'(pixelOn), 32'(e.on));
            chk("pixelIndex", 32'(pixelIndex), 32'(e.idx));
        end
    end

    task automatic rd(input logic on, input logic [20:0] a, input logic eo, input logic [3:0] ei);
        @(negedge frame_Clk);
        playerOn      = on;
        spriteAddress = a;
        sbq.push_back('{due: cyc + 2, on: eo, idx: ei});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge frame_Clk);
            playerOn   = 1'b0;
            load_valid = 1'b0;
            load_start = 1'b0;
        end
    endtask

    task automatic pulse_start();
        @(negedge frame_Clk);
        load_start = 1'b1;
        load_valid = 1'b0;
        playerOn   = 1'b0;
        @(negedge frame_Clk);
        load_start = 1'b0;
    endtask

    // Streams n accepted words with data (index+ofs)[3:0]. Returns at the
    // negedge where the last word is presented (written on the next posedge).
    task automatic stream(input int n, input bit toggle, input int ofs, input bit rd_busy,
                          output int acc, output int rdy_cyc);
        int budget;
        bit v;
        budget  = 0;
        v       = 1'b1;
        acc     = 0;
        rdy_cyc = 0;
        while (acc < n && budget < 40000) begin
            if (budget > 0) @(negedge frame_Clk);
            budget++;
            v = toggle ? ~v : 1'b1;
            load_valid = v;
            load_data  = 4'(acc + ofs);
            if (rd_busy) begin
                playerOn      = 1'b1;
                spriteAddress = 21'(acc);
                sbq.push_back('{due: cyc + 2, on: 1'b0, idx: 4'h0});
            end
            if (load_ready) rdy_cyc++;
            if (v && load_ready) acc++;
        end
        if (acc < n) chk("load_timeout_words", 32'(acc), 32'(n));
    endtask

    task automatic finish_full_load(input string nm);
        chk({nm, "_sprite_ready_before_last"}, 32'(sprite_ready), 32'd0);
        @(negedge frame_Clk);
        load_valid = 1'b0;
        playerOn   = 1'b0;
        chk({nm, "_sprite_ready_after_last"}, 32'(sprite_ready), 32'd1);
        chk({nm, "_load_ready_after_last"}, 32'(load_ready), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int rdy;

        tbl[0]  = '{1'b1, 21'd1,     1'b1, 4'h1};
        tbl[1]  = '{1'b1, 21'd2,     1'b1, 4'h2};
        tbl[2]  = '{1'b1, 21'd3,     1'b1, 4'h3};
        tbl[3]  = '{1'b1, 21'd16,    1'b0, 4'h0};
        tbl[4]  = '{1'b1, 21'd17,    1'b1, 4'h1};
        tbl[5]  = '{1'b0, 21'd5,     1'b0, 4'h0};
        tbl[6]  = '{1'b1, 21'd12799, 1'b1, 4'hF};
        tbl[7]  = '{1'b1, 21'd0,     1'b0, 4'h0};
        tbl[8]  = '{1'b1, 21'd1234,  1'b1, 4'h2};
        tbl[9]  = '{1'b1, 21'd255,   1'b1, 4'hF};
        tbl[10] = '{1'b1, 21'd4103,  1'b1, 4'h7};

        // Reset state
        repeat (3) @(negedge frame_Clk);
        chk("rst_load_ready", 32'(load_ready), 32'd0);
        chk("rst_sprite_ready", 32'(sprite_ready), 32'd0);
        chk("rst_pixelOn", 32'(pixelOn), 32'd0);
        chk("rst_pixelIndex", 32'(pixelIndex), 32'd0);
`ifdef SPRITE_BOUND_CHECK_EN
        chk("rst_addr_error", 32'(addr_error), 32'd0);
`endif
        Reset = 1'b0;

        // Reads before any load are suppressed
        rd(1'b1, 21'd1, 1'b0, 4'h0);
        rd(1'b1, 21'd2, 1'b0, 4'h0);
        idle(3);
        chk("empty_load_ready", 32'(load_ready), 32'd0);

        // First full load, continuous valid
        pulse_start();
        chk("load_ready_in_load", 32'(load_ready), 32'd1);
        stream(12800, 1'b0, 0, 1'b0, acc, rdy);
        chk("load1_ready_cycles", 32'(rdy), 32'd12800);
        finish_full_load("load1");

        // Table-driven reads on consecutive cycles
        foreach (tbl[i]) rd(tbl[i].on_in, tbl[i].addr, tbl[i].exp_on, tbl[i].exp_idx);
`ifndef SPRITE_BOUND_CHECK_EN
        // Upper address bits are dropped: 0x4003 -> word 3
        rd(1'b1, 21'h04003, 1'b1, 4'h3);
`endif
        idle(4);

        // Reload with toggled valid, restart at word 500, reads during load
        pulse_start();
        chk("reload_sprite_ready", 32'(sprite_ready), 32'd0);
        chk("reload_load_ready", 32'(load_ready), 32'd1);
        stream(500, 1'b1, 0, 1'b1, acc, rdy);
        @(negedge frame_Clk);
        load_start = 1'b1;
        load_valid = 1'b1;
        load_data  = 4'hF;
        playerOn   = 1'b0;
        @(negedge frame_Clk);
        load_start = 1'b0;
        load_valid = 1'b0;
        chk("restart_load_ready", 32'(load_ready), 32'd1);
        chk("restart_sprite_ready", 32'(sprite_ready), 32'd0);
        stream(12800, 1'b0, 3, 1'b0, acc, rdy);
        chk("load2_ready_cycles", 32'(rdy), 32'd12800);
        finish_full_load("load2");

        // Reads against the reloaded data (addr+3)[3:0]
        rd(1'b1, 21'd13,    1'b0, 4'h0);
        rd(1'b1, 21'd14,    1'b1, 4'h1);
        rd(1'b1, 21'd12799, 1'b1, 4'h2);
        rd(1'b1, 21'd500,   1'b1, 4'h7);
        rd(1'b1, 21'd0,     1'b1, 4'h3);
        idle(4);

`ifdef SPRITE_BOUND_CHECK_EN
        chk("bound_err_clear", 32'(addr_error), 32'd0);
        rd(1'b1, 21'd12800, 1'b0, 4'h0);
        rd(1'b1, 21'd12799, 1'b1, 4'h2);
        idle(2);
        chk("bound_err_set", 32'(addr_error), 32'd1);
        idle(3);
        chk("bound_err_held", 32'(addr_error), 32'd1);
        pulse_start();
        chk("bound_err_cleared_by_start", 32'(addr_error), 32'd0);
`endif

        // Reset mid-load abandons the load
        pulse_start();
        stream(100, 1'b0, 0, 1'b0, acc, rdy);
        @(negedge frame_Clk);
        Reset      = 1'b1;
        load_valid = 1'b1;
        @(negedge frame_Clk);
        chk("midrst_load_ready", 32'(load_ready), 32'd0);
        chk("midrst_sprite_ready", 32'(sprite_ready), 32'd0);
        Reset = 1'b0;
        repeat (5) @(negedge frame_Clk);
        chk("postrst_load_ready", 32'(load_ready), 32'd0);
        chk("postrst_sprite_ready", 32'(sprite_ready), 32'd0);
        load_valid = 1'b0;
        rd(1'b1, 21'd1, 1'b0, 4'h0);
        idle(5);
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
